vga_timing_gen: RTL and testbench

Parametrised VGA/DVI raster timing generator that replaces the fixed 640x480 controller. It supports any resolution up to 4095x4095 totals, configurable sync polarity and configurable blanking colour. A pixel-request lead matches pixel sources with 0..4 cycles of read latency. All display outputs are registered, and the block adds run enable, frame/line strobes and a frame counter. It sits between the pixel/sprite compositor (pix_x/pix_y -> pix_data) and the video DAC/encoder.

---
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the raster timing generator and the pixel source.
// master: timing side (drives req/x/y, samples data); slave: pixel source.
interface vga_timing_gen_if #(
  parameter int DATA_W = 16
);
  logic              pix_req;
  logic [10:0]       pix_x;
  logic [10:0]       pix_y;
  logic [DATA_W-1:0] pix_data;

  modport master (
    output pix_req, pix_x, pix_y,
    input  pix_data
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    output pix_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with a leading pixel request.
// Ports: vga_clk, sys_rst_n, en; pix (request bus, master);
//   hsync, vsync, rgb, rgb_valid, line_start, frame_start, frame_cnt.
module vga_timing_gen #(
  parameter int                 H_SYNC      = 96,
  parameter int                 H_BACK      = 48,
  parameter int                 H_VALID     = 640,
  parameter int                 H_FRONT     = 16,
  parameter int                 V_SYNC      = 2,
  parameter int                 V_BACK      = 33,
  parameter int                 V_VALID     = 480,
  parameter int                 V_FRONT     = 10,
  parameter bit                 HS_POL      = 1'b1,
  parameter bit                 VS_POL      = 1'b1,
  parameter int                 REQ_LEAD    = 1,
  parameter int                 DATA_W      = 16,
  parameter logic [DATA_W-1:0]  BLANK_COLOR = '0
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  vga_timing_gen_if.master  pix,
  output logic              hsync,
  output logic              vsync,
  output logic [DATA_W-1:0] rgb,
  output logic              rgb_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK;
  localparam int VS      = V_SYNC + V_BACK;

  if (REQ_LEAD < 0 || REQ_LEAD > 4 || REQ_LEAD > H_BACK) begin : g_bad_lead
    $error("vga_timing_gen: REQ_LEAD out of range");
  end
  if (H_SYNC < 1 || H_BACK < 1 || H_VALID < 1 || H_FRONT < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal parameter is zero");
  end
  if (V_SYNC < 1 || V_BACK < 1 || V_VALID < 1 || V_FRONT < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical parameter is zero");
  end
  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_tot
    $error("vga_timing_gen: total exceeds 4095");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SY   = 12'(H_SYNC);
  localparam logic [11:0] V_SY   = 12'(V_SYNC);
  localparam logic [11:0] H_A0   = 12'(HS);
  localparam logic [11:0] H_A1   = 12'(HS + H_VALID);
  localparam logic [11:0] V_A0   = 12'(VS);
  localparam logic [11:0] V_A1   = 12'(VS + V_VALID);
  localparam logic [11:0] H_R0   = 12'(HS - REQ_LEAD);
  localparam logic [11:0] H_R1   = 12'(HS + H_VALID - REQ_LEAD);

  logic [11:0] cnt_h;
  logic [11:0] cnt_v;
  logic        h_end;
  logic        v_end;
  logic        v_win;
  logic        hs_act;
  logic        vs_act;
  logic        act;
  logic        req;
  logic        ls_nxt;
  logic        fs_nxt;

  assign h_end = (cnt_h == H_LAST);
  assign v_end = (cnt_v == V_LAST);

  // en low parks the raster at (0,0) so a restart begins a fresh frame.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (!en) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      cnt_h <= h_end ? 12'd0 : cnt_h + 12'd1;
      if (h_end)
        cnt_v <= v_end ? 12'd0 : cnt_v + 12'd1;
    end
  end

  always_comb begin
    v_win  = (cnt_v >= V_A0) && (cnt_v < V_A1);
    hs_act = en && (cnt_h < H_SY);
    vs_act = en && (cnt_v < V_SY);
    act    = en && v_win && (cnt_h >= H_A0) && (cnt_h < H_A1);
    req    = en && v_win && (cnt_h >= H_R0) && (cnt_h < H_R1);
    ls_nxt = en && (cnt_h == 12'd0);
    fs_nxt = ls_nxt && (cnt_v == 12'd0);
  end

  // Request leads the capture by REQ_LEAD; x/y wrap modulo 2^11.
  assign pix.pix_req = req;
  assign pix.pix_x   = req ? cnt_h[10:0] + 11'(REQ_LEAD) - 11'(HS) : 11'h7FF;
  assign pix.pix_y   = req ? cnt_v[10:0] - 11'(VS) : 11'h7FF;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      rgb         <= BLANK_COLOR;
      rgb_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      hsync       <= hs_act ? HS_POL : !HS_POL;
      vsync       <= vs_act ? VS_POL : !VS_POL;
      rgb         <= act ? pix.pix_data : BLANK_COLOR;
      rgb_valid   <= act;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two small rasters (lead 3 / pos
// polarity, lead 0 / neg polarity), table vectors plus en-drop and reset.
module tb_vga_timing_gen;

  localparam logic [15:0] BL = 16'h00F0;
  localparam logic [10:0] NA = 11'h7FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_b_n, en, en_b;

  logic        hs_a, vs_a, rv_a, ls_a, fs_a;
  logic [15:0] rgb_a;
  logic [7:0]  fc_a;
  logic        hs_b, vs_b, rv_b, ls_b, fs_b;
  logic [7:0]  rgb_b;
  logic [7:0]  fc_b;

  vga_timing_gen_if #(.DATA_W(16)) pa ();
  vga_timing_gen_if #(.DATA_W(8))  pb ();

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(4), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(3),
    .DATA_W(16), .BLANK_COLOR(16'h00F0)
  ) dut_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .en(en), .pix(pa),
    .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .rgb_valid(rv_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_SYNC(3), .H_BACK(2), .H_VALID(5), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(0),
    .DATA_W(8), .BLANK_COLOR(8'h00)
  ) dut_b (
    .vga_clk(clk), .sys_rst_n(rst_b_n), .en(en_b), .pix(pb),
    .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .rgb_valid(rv_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // Source A: three-cycle read latency, data = {y[4:0], x[10:0]}.
  logic [15:0] pipe_a [3];
  always @(posedge clk) begin
    pipe_a[0] <= {pa.pix_y[4:0], pa.pix_x};
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
  end
  assign pa.pix_data = pipe_a[2];

  // Source B: combinational.
  assign pb.pix_data = {pb.pix_y[2:0], pb.pix_x[4:0]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [51:0] pk(
    input logic hs, input logic vs, input logic rv, input logic ls,
    input logic fs, input logic [15:0] rgb, input logic req,
    input logic [10:0] x, input logic [10:0] y, input logic [7:0] fc);
    return {hs, vs, rv, ls, fs, rgb, req, x, y, fc};
  endfunction

  function automatic logic [51:0] obs_a();
    return pk(hs_a, vs_a, rv_a, ls_a, fs_a, rgb_a,
              pa.pix_req, pa.pix_x, pa.pix_y, fc_a);
  endfunction

  typedef struct {
    int          cyc;
    logic [51:0] exp;
  } vec_t;

  vec_t tv[$];

  initial begin
    int cur;
    int n_hs, n_vs, n_rv, n_ls, n_fs, bad;
    int nb_hs, nb_vs, nb_rv, bad_b;
    int p, h, v;
    logic [15:0] e16;
    logic [7:0]  e8;

    tv.push_back('{1,   pk(1'b1,1'b1,1'b0,1'b1,1'b1,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{4,   pk(1'b1,1'b1,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{5,   pk(1'b0,1'b1,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{19,  pk(1'b1,1'b1,1'b0,1'b1,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{37,  pk(1'b1,1'b0,1'b0,1'b1,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{77,  pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b1,11'd0,11'd0,8'd1)});
    tv.push_back('{81,  pk(1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1,11'd4,11'd0,8'd1)});
    tv.push_back('{84,  pk(1'b0,1'b0,1'b1,1'b0,1'b0,16'h0003,1'b1,11'd7,11'd0,8'd1)});
    tv.push_back('{85,  pk(1'b0,1'b0,1'b1,1'b0,1'b0,16'h0004,1'b0,NA,NA,8'd1)});
    tv.push_back('{88,  pk(1'b0,1'b0,1'b1,1'b0,1'b0,16'h0007,1'b0,NA,NA,8'd1)});
    tv.push_back('{89,  pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{131, pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b1,11'd0,11'd3,8'd1)});
    tv.push_back('{142, pk(1'b0,1'b0,1'b1,1'b0,1'b0,16'h1807,1'b0,NA,NA,8'd1)});
    tv.push_back('{153, pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd1)});
    tv.push_back('{163, pk(1'b1,1'b1,1'b0,1'b1,1'b1,BL,1'b0,NA,NA,8'd2)});
    tv.push_back('{164, pk(1'b1,1'b1,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd2)});
    tv.push_back('{325, pk(1'b1,1'b1,1'b0,1'b1,1'b1,BL,1'b0,NA,NA,8'd3)});

    rst_n = 1'b0; rst_b_n = 1'b0; en = 1'b1; en_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset", 64'(obs_a()),
        64'(pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd0)));
    chk("b_reset", 64'({hs_b, vs_b, rv_b, ls_b, fs_b, rgb_b, fc_b}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
    rst_n = 1'b1; rst_b_n = 1'b1;
    cur = 0;

    foreach (tv[i]) begin
      repeat (tv[i].cyc - cur) @(posedge clk);
      @(negedge clk);
      cur = tv[i].cyc;
      chk($sformatf("vec_c%0d", cur), 64'(obs_a()), 64'(tv[i].exp));
    end

    // One A frame (162 cycles) and one B frame (first 66 of them).
    n_hs = 0; n_vs = 0; n_rv = 0; n_ls = 0; n_fs = 0; bad = 0;
    nb_hs = 0; nb_vs = 0; nb_rv = 0; bad_b = 0;
    for (int c = 326; c <= 487; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_hs += int'(hs_a); n_vs += int'(vs_a); n_rv += int'(rv_a);
      n_ls += int'(ls_a); n_fs += int'(fs_a);
      p = c - 1; h = p % 18; v = (p / 18) % 9;
      if (h >= 8 && h < 16 && v >= 4 && v < 8) begin
        e16 = {5'(v - 4), 11'(h - 8)};
        if (!rv_a || rgb_a !== e16) bad++;
      end else if (rv_a || rgb_a !== BL) bad++;
      if (c <= 391) begin
        nb_hs += int'(!hs_b); nb_vs += int'(!vs_b); nb_rv += int'(rv_b);
        h = p % 11; v = (p / 11) % 6;
        if (h >= 5 && h < 10 && v >= 2 && v < 5) begin
          e8 = {3'(v - 2), 5'(h - 5)};
          if (!rv_b || rgb_b !== e8) bad_b++;
        end else if (rv_b || rgb_b !== 8'h00) bad_b++;
      end
    end
    cur = 487;
    chk("a_hsync_cnt", 64'(n_hs), 64'd36);
    chk("a_vsync_cnt", 64'(n_vs), 64'd36);
    chk("a_valid_cnt", 64'(n_rv), 64'd32);
    chk("a_line_cnt",  64'(n_ls), 64'd9);
    chk("a_frame_cnt", 64'(n_fs), 64'd1);
    chk("a_rgb_window", 64'(bad), 64'd0);
    chk("b_hsync_low", 64'(nb_hs), 64'd18);
    chk("b_vsync_low", 64'(nb_vs), 64'd11);
    chk("b_valid_cnt", 64'(nb_rv), 64'd15);
    chk("b_rgb_window", 64'(bad_b), 64'd0);

    // Drop en at (12,5), hold ten cycles, restart.
    repeat (588 - cur) @(posedge clk);
    @(negedge clk);
    chk("drop_pre_req", 64'({pa.pix_req, pa.pix_x, pa.pix_y}),
        64'({1'b1, 11'd7, 11'd1}));
    en = 1'b0;
    #1;
    chk("drop_comb", 64'({pa.pix_req, pa.pix_x, pa.pix_y}),
        64'({1'b0, NA, NA}));
    @(negedge clk);
    chk("drop_reg", 64'(obs_a()),
        64'(pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd4)));
    repeat (9) @(negedge clk);
    chk("drop_hold", 64'(obs_a()),
        64'(pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd4)));
    en = 1'b1;
    #1;
    chk("restart_comb", 64'({pa.pix_req, pa.pix_x}), 64'({1'b0, NA}));
    @(negedge clk);
    chk("restart_fs", 64'(obs_a()),
        64'(pk(1'b1,1'b1,1'b0,1'b1,1'b1,BL,1'b0,NA,NA,8'd5)));
    @(negedge clk);
    chk("restart_fs_once", 64'(obs_a()),
        64'(pk(1'b1,1'b1,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd5)));

    // Async reset in the middle of an active line.
    repeat (79) @(negedge clk);
    chk("pre_rst_active", 64'({rv_a, rgb_a}), 64'({1'b1, 16'h0000}));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(obs_a()),
        64'(pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 64'(obs_a()),
        64'(pk(1'b0,1'b0,1'b0,1'b0,1'b0,BL,1'b0,NA,NA,8'd0)));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fs", 64'(obs_a()),
        64'(pk(1'b1,1'b1,1'b0,1'b1,1'b1,BL,1'b0,NA,NA,8'd1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
